// File: rtl/boreal_frame_serializer.sv
// Boreal frame serializer: accepts 8-channel frames into a ping-pong pair of
// slots and streams them one sample per cycle, oldest frame first, with an
// optional per-channel DC-offset tracker in front of the output register.
module boreal_frame_serializer #(
  parameter int N_CH     = 8,
  parameter int DC_EN    = 1,
  parameter int DC_SHIFT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [127:0]        in_frame,
  output logic                in_ready,
  output logic                out_valid,
  output logic signed [15:0]  out_sample,
  output logic [2:0]          out_ch,
  output logic                out_last,
  output logic                overrun,
  output logic [15:0]         frame_count
);

  localparam int         DATA_W  = 16;
  localparam int         OFF_W   = 24;
  localparam logic [2:0] LAST_CH = 3'(N_CH - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam logic signed [DATA_W:0] SAT_HI = 17'sh07fff;
  localparam logic signed [DATA_W:0] SAT_LO = 17'sh18000;

  // Clamp a 17-bit difference into the signed 16-bit output range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [DATA_W:0] v);
    if (v > SAT_HI) return 16'sh7fff;
    if (v < SAT_LO) return 16'sh8000;
    return v[DATA_W-1:0];
  endfunction

  // One step of the first-order DC tracker in Q16.8:
  // off + ((x<<8) - off) >>> DC_SHIFT. The result stays between off and x<<8,
  // so it always fits back into 24 bits.
  function automatic logic signed [OFF_W-1:0] dc_next(input logic signed [OFF_W-1:0] off,
                                                      input logic signed [DATA_W-1:0] x);
    logic signed [OFF_W:0] err;
    logic signed [OFF_W:0] acc;
    err = $signed({x[DATA_W-1], x, 8'h00}) - $signed({off[OFF_W-1], off});
    acc = $signed({off[OFF_W-1], off}) + (err >>> DC_SHIFT);
    return acc[OFF_W-1:0];
  endfunction

  logic [0:0]                state_q, state_d;
  logic [2:0]                ch_q, ch_d;
  logic                      rd_ptr_q, rd_ptr_d;
  logic                      wr_ptr_q, wr_ptr_d;
  logic [1:0]                full_q, full_d;
  logic [1:0][127:0]         slot_q, slot_d;
  logic                      overrun_q, overrun_d;
  logic [15:0]               frame_count_q, frame_count_d;
  logic signed [OFF_W-1:0]   off_q [N_CH];
  logic signed [OFF_W-1:0]   off_d [N_CH];
  logic                      out_valid_q, out_valid_d;
  logic [2:0]                out_ch_q, out_ch_d;
  logic                      out_last_q, out_last_d;
  logic signed [DATA_W-1:0]  out_sample_q, out_sample_d;

  logic                      accept;
  logic                      drop;
  logic                      emit;
  logic [2:0]                emit_ch;
  logic [127:0]              emit_frame;
  logic signed [DATA_W-1:0]  emit_x;
  logic signed [DATA_W:0]    dc_diff;

  // A slot is free whenever the registered state shows fewer than two full slots.
  assign in_ready = ~(full_q[0] & full_q[1]);
  assign accept   = in_valid & in_ready;
  assign drop     = in_valid & ~in_ready;

  // Slot bookkeeping, streamer sequencing and the DC-corrected output sample.
  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    full_d        = full_q;
    slot_d        = slot_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;
    off_d         = off_q;
    out_valid_d   = 1'b0;
    out_ch_d      = out_ch_q;
    out_last_d    = out_last_q;
    out_sample_d  = out_sample_q;
    emit          = 1'b0;
    emit_ch       = ch_q;
    emit_frame    = slot_q[rd_ptr_q];
    emit_x        = '0;
    dc_diff       = '0;

    // Slots are filled and drained in the same order, so the write pointer
    // always lands on the free slot whenever in_ready is high.
    if (accept) begin
      slot_d[wr_ptr_q] = in_frame;
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
      frame_count_d    = frame_count_q + 16'd1;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // Channel 0 comes from a waiting slot (back-to-back case) or straight
        // from the incoming frame, so it is registered on the accept edge.
        emit_ch = '0;
        if (full_q[rd_ptr_q]) begin
          emit = 1'b1;
        end else if (accept) begin
          emit       = 1'b1;
          emit_frame = in_frame;
        end
        if (emit) begin
          state_d = ST_STREAM;
          ch_d    = 3'd1;
        end
      end
      default: begin
        emit = 1'b1;
        if (ch_q == LAST_CH) begin
          // Slot is released on the edge that registers its last sample.
          full_d[rd_ptr_q] = 1'b0;
          rd_ptr_d         = ~rd_ptr_q;
          state_d          = ST_IDLE;
          ch_d             = '0;
        end else begin
          ch_d = ch_q + 3'd1;
        end
      end
    endcase

    if (emit) begin
      emit_x      = emit_frame[{emit_ch, 4'b0000} +: DATA_W];
      dc_diff     = $signed({emit_x[DATA_W-1], emit_x})
                  - $signed({off_q[emit_ch][OFF_W-1], off_q[emit_ch][OFF_W-1:8]});
      out_valid_d = 1'b1;
      out_ch_d    = emit_ch;
      out_last_d  = (emit_ch == LAST_CH);
      if (DC_EN != 0) begin
        out_sample_d    = sat16(dc_diff);
        off_d[emit_ch]  = dc_next(off_q[emit_ch], emit_x);
      end else begin
        out_sample_d = emit_x;
      end
    end
  end

  // Control, offsets and output registers; reset discards any buffered frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ch_q          <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      full_q        <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
      out_valid_q   <= 1'b0;
      out_ch_q      <= '0;
      out_last_q    <= 1'b0;
      out_sample_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        off_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      full_q        <= full_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      out_valid_q   <= out_valid_d;
      out_ch_q      <= out_ch_d;
      out_last_q    <= out_last_d;
      out_sample_q  <= out_sample_d;
      off_q         <= off_d;
    end
  end

  // Frame storage is pure data; its contents are qualified by full_q.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign out_valid   = out_valid_q;
  assign out_sample  = out_sample_q;
  assign out_ch      = out_ch_q;
  assign out_last    = out_last_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule
